// File: rtl/wb_slave_regbank.sv
// wb_slave_regbank: 32-bit WISHBONE slave register bank with byte lanes, wait states and ERR on bad addresses.
// Optional RTY injection under WB_SLAVE_RTY_EN. Rev 1.0
`default_nettype none

module wb_slave_regbank #(
  parameter int AW          = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 0,
  parameter int RTY_PERIOD  = 4
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [3:0]    SEL_I,
  input  logic [31:0]   DAT_I,
  output logic [31:0]   DAT_O,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          RTY_O
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wcnt;
  logic                    lat_we;
  logic [AW-1:0]           lat_adr;
  logic [3:0]              lat_sel;
  logic [31:0]             lat_dat;
  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    cur_we;
  logic [AW-1:0]           cur_adr;
  logic [3:0]              cur_sel;
  logic [31:0]             cur_dat;
  logic                    illegal;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    term;
  logic                    retry;
  logic                    do_write;

  assign req = CYC_I & STB_I;

  // With no wait states the request terminates on the sampling edge, before anything is latched.
  always_comb begin
    cur_we  = lat_we;
    cur_adr = lat_adr;
    cur_sel = lat_sel;
    cur_dat = lat_dat;
    if (state == IDLE) begin
      cur_we  = WE_I;
      cur_adr = ADR_I;
      cur_sel = SEL_I;
      cur_dat = DAT_I;
    end
  end

  assign illegal  = (cur_adr[1:0] != 2'b00) || ((cur_adr >> (DEPTH_LOG2 + 2)) != '0);
  assign idx      = cur_adr[DEPTH_LOG2+1:2];
  assign term     = req && (((state == IDLE) && (WAIT_STATES == 0)) ||
                            ((state == WAITING) && (wcnt == 4'd1)));

`ifdef WB_SLAVE_RTY_EN
  localparam int CW = $clog2(RTY_PERIOD + 1);
  logic [CW-1:0] rcnt;

  assign retry = !illegal && (rcnt == CW'(RTY_PERIOD - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rcnt <= '0;
    end else if (term && !illegal) begin
      rcnt <= retry ? '0 : rcnt + 1'b1;
    end
  end
`else
  assign retry = 1'b0;
`endif

  assign do_write = term && cur_we && !illegal && !retry;

  always_ff @(posedge CLK_I) begin
    if (do_write && !RST_I) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      lat_we  <= 1'b0;
      lat_adr <= '0;
      lat_sel <= 4'd0;
      lat_dat <= 32'd0;
      ACK_O   <= 1'b0;
      ERR_O   <= 1'b0;
      RTY_O   <= 1'b0;
      DAT_O   <= 32'd0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      DAT_O <= 32'd0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_we  <= WE_I;
            lat_adr <= ADR_I;
            lat_sel <= SEL_I;
            lat_dat <= DAT_I;
            wcnt    <= 4'(WAIT_STATES);
            state   <= (WAIT_STATES == 0) ? RESP : WAITING;
          end
        end
        WAITING: begin
          if (!req) begin
            state <= IDLE;
          end else if (wcnt == 4'd1) begin
            wcnt  <= 4'd0;
            state <= RESP;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (term) begin
        if (illegal) begin
          ERR_O <= 1'b1;
        end else if (retry) begin
          RTY_O <= 1'b1;
        end else begin
          ACK_O <= 1'b1;
          if (!cur_we) DAT_O <= mem[idx];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_regbank.sv
// tb_wb_slave_regbank: randomized check of two wb_slave_regbank instances (0 and 3 wait states) against a model.
`default_nettype none

module tb_wb_slave_regbank;

  localparam int RTY_P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc = '0;
  logic [1:0]  stb = '0;
  logic [1:0]  we  = '0;
  logic [7:0]  adr   [2];
  logic [3:0]  sel   [2];
  logic [31:0] dat_i [2];
  logic [31:0] dat_o [2];
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [1:0]  rty_o;

  logic [31:0] mem_m [2][16];
`ifdef WB_SLAVE_RTY_EN
  int rcnt [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_slave_regbank #(.AW(8), .DEPTH_LOG2(4), .WAIT_STATES(0), .RTY_PERIOD(RTY_P)) u_dut0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
    .ADR_I(adr[0]), .SEL_I(sel[0]), .DAT_I(dat_i[0]), .DAT_O(dat_o[0]),
    .ACK_O(ack_o[0]), .ERR_O(err_o[0]), .RTY_O(rty_o[0])
  );

  wb_slave_regbank #(.AW(8), .DEPTH_LOG2(4), .WAIT_STATES(3), .RTY_PERIOD(RTY_P)) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
    .ADR_I(adr[1]), .SEL_I(sel[1]), .DAT_I(dat_i[1]), .DAT_O(dat_o[1]),
    .ACK_O(ack_o[1]), .ERR_O(err_o[1]), .RTY_O(rty_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] flags(input int d);
    return {29'd0, rty_o[d], err_o[d], ack_o[d]};
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic reset_model();
`ifdef WB_SLAVE_RTY_EN
    rcnt[0] = 0;
    rcnt[1] = 0;
`endif
  endtask

  // Expected outcome comes from the address rules and a word array; kind is {rty,err,ack}.
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [2:0] kind);
    logic [31:0] exp_dat;
    int n;
    bit hold;
    exp_dat = 32'd0;
    if (a[1:0] != 2'b00 || a[7:6] != 2'b00) begin
      kind = 3'b010;
    end else begin
      kind = 3'b001;
`ifdef WB_SLAVE_RTY_EN
      if (rcnt[d] + 1 == RTY_P) begin
        kind    = 3'b100;
        rcnt[d] = 0;
      end else begin
        rcnt[d]++;
      end
`endif
      if (kind == 3'b001) begin
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_dat = mem_m[d][a[5:2]];
        end
      end
    end
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_i[d] = wd;
    n = 0;
    while (flags(d) == 32'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("lat%0d", d), n, ws_of(d) + 1);
    chk($sformatf("kind%0d a=%h", d, a), flags(d), {29'd0, kind});
    chk($sformatf("rdat%0d a=%h", d, a), dat_o[d], exp_dat);
    hold = $urandom_range(0, 1) == 1;
    if (hold) begin
      @(negedge clk);
      chk($sformatf("gap%0d", d), flags(d), 32'd0);
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end else begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("gap%0d", d), flags(d), 32'd0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [2:0]  k;
    logic [31:0] acc;
    logic [7:0]  a;
    int          n;
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; sel[d] = '0; dat_i[d] = '0;
    end
    reset_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_flags%0d", d), flags(d), 32'd0);
      chk($sformatf("rst_dat%0d", d), dat_o[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Give every word a known value before anything reads it.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        k = 3'b000;
        for (int t = 0; t < 3 && k != 3'b001; t++)
          xfer(d, 1'b1, 8'(i * 4), 4'hF, $urandom, k);
      end

    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 8'h04, 4'hF, 32'h12345678, k);
      xfer(d, 1'b0, 8'h04, 4'hF, 32'h0, k);
      xfer(d, 1'b1, 8'h08, 4'hF, 32'hFFFFFFFF, k);
      xfer(d, 1'b1, 8'h08, 4'b0001, 32'h000000AA, k);
      xfer(d, 1'b1, 8'h08, 4'b1000, 32'hBB000000, k);
      xfer(d, 1'b0, 8'h08, 4'hF, 32'h0, k);
      xfer(d, 1'b1, 8'h08, 4'b0000, 32'h01020304, k);
      xfer(d, 1'b0, 8'h08, 4'hF, 32'h0, k);
      xfer(d, 1'b0, 8'h40, 4'hF, 32'h0, k);
      xfer(d, 1'b1, 8'h05, 4'hF, 32'hCAFEF00D, k);
      xfer(d, 1'b0, 8'h04, 4'hF, 32'h0, k);
    end

    // Abort a waited write by dropping CYC after two edges.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h10; sel[1] = 4'hF; dat_i[1] = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    acc = 32'd0;
    repeat (6) begin
      @(negedge clk);
      acc |= flags(1);
    end
    chk("abort_flags", acc, 32'd0);
    xfer(1, 1'b0, 8'h10, 4'hF, 32'h0, k);

    // Reset pulse in the middle of a waited write.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h0C; sel[1] = 4'hF; dat_i[1] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_wait_flags", flags(1), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    xfer(1, 1'b0, 8'h0C, 4'hF, 32'h0, k);

    // Reset while the read response is on the bus must clear it at once.
    reset_model();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h0C; sel[1] = 4'hF;
    n = 0;
    while (ack_o[1] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("resp_ack", 32'(ack_o[1]), 32'd1);
    chk("resp_dat", dat_o[1], mem_m[1][3]);
    #2 rst = 1'b1;
    #1 chk("resp_rst_flags", flags(1), 32'd0);
    chk("resp_rst_dat", dat_o[1], 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    // Random mix of legal, misaligned and out-of-window accesses.
    for (int i = 0; i < 120; i++) begin
      int d;
      int r;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 8'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 8'($urandom_range(16, 63) * 4);
      else             a = 8'($urandom_range(0, 15) * 4);
      xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
